// File: rtl/decode_control_pipe.sv
// decode_control_pipe: registered RV32I control decoder with an in-order
// output buffer, valid/ready handshakes on both sides, flush and a
// saturating illegal-instruction counter.
module decode_control_pipe #(
   parameter int ADDR_W    = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [4:0]        out_alu_op,
   output logic [31:0]       out_imm,
   output logic [4:0]        out_rs1,
   output logic [4:0]        out_rs2,
   output logic [4:0]        out_rd,
   output logic              out_reg_write_en,
   output logic              out_alu_src_imm,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_mem_to_reg,
   output logic              out_mem_unsigned,
   output logic              out_jump,
   output logic              out_jump_reg,
   output logic [1:0]        out_mem_size,
   output logic [2:0]        out_branch_type,
   output logic              out_illegal,
   output logic [15:0]       illegal_count
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,  ALU_ADDI  = 5'd1,  ALU_SUB  = 5'd2,
      ALU_SLL   = 5'd4,  ALU_SLLI  = 5'd5,  ALU_SRL  = 5'd6,
      ALU_SRLI  = 5'd7,  ALU_SRA   = 5'd8,  ALU_SRAI = 5'd9,
      ALU_AND   = 5'd10, ALU_ANDI  = 5'd11, ALU_OR   = 5'd12,
      ALU_ORI   = 5'd13, ALU_XOR   = 5'd14, ALU_XORI = 5'd15,
      ALU_IMM   = 5'd16, ALU_SLT   = 5'd17, ALU_SLTU = 5'd18,
      ALU_SLTI  = 5'd19, ALU_SLTIU = 5'd20, ALU_AUIPC = 5'd21
   } alu_op_e;

   typedef enum logic [6:0] {
      OPC_OP     = 7'b0110011,
      OPC_OP_IMM = 7'b0010011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_BRANCH = 7'b1100011,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111
   } opcode_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      alu_op_e           alu_op;
      logic [31:0]       imm;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic              reg_write_en;
      logic              alu_src_imm;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
      logic              mem_unsigned;
      logic              jump;
      logic              jump_reg;
      logic [1:0]        mem_size;
      logic [2:0]        branch_type;
      logic              illegal;
   } entry_t;

   opcode_e     opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  f_rs1, f_rs2, f_rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   entry_t      dec;
   logic        bad;

   entry_t           buf_q [BUF_DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [15:0]      illegal_count_q, illegal_count_d;
   logic             push, pop;
   entry_t           head;

   assign opcode = opcode_e'(in_instr[6:0]);
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign f_rd   = in_instr[11:7];
   assign f_rs1  = in_instr[19:15];
   assign f_rs2  = in_instr[24:20];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

   // Decode the offered instruction into a buffer entry; illegal encodings collapse to a bare PC + flag.
   always_comb begin
      dec    = '0;
      dec.pc = in_pc;
      bad    = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec.rs1 = f_rs1;
            dec.rs2 = f_rs2;
            dec.rd  = f_rd;
            dec.reg_write_en = 1'b1;
            case (funct3)
               3'd0:    dec.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
               3'd1:    dec.alu_op = ALU_SLL;
               3'd2:    dec.alu_op = ALU_SLT;
               3'd3:    dec.alu_op = ALU_SLTU;
               3'd4:    dec.alu_op = ALU_XOR;
               3'd5:    dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
               3'd6:    dec.alu_op = ALU_OR;
               default: dec.alu_op = ALU_AND;
            endcase
         end
         OPC_OP_IMM: begin
            dec.rs1 = f_rs1;
            dec.rd  = f_rd;
            dec.imm = imm_i;
            dec.reg_write_en = 1'b1;
            dec.alu_src_imm  = 1'b1;
            case (funct3)
               3'd0: dec.alu_op = ALU_ADDI;
               3'd1: begin
                  dec.alu_op = ALU_SLLI;
                  bad = (funct7 != 7'b0000000);
               end
               3'd2: dec.alu_op = ALU_SLTI;
               3'd3: dec.alu_op = ALU_SLTIU;
               3'd4: dec.alu_op = ALU_XORI;
               3'd5: begin
                  if (funct7 == 7'b0000000)      dec.alu_op = ALU_SRLI;
                  else if (funct7 == 7'b0100000) dec.alu_op = ALU_SRAI;
                  else                           bad = 1'b1;
               end
               3'd6:    dec.alu_op = ALU_ORI;
               default: dec.alu_op = ALU_ANDI;
            endcase
         end
         OPC_LOAD: begin
            dec.rs1 = f_rs1;
            dec.rd  = f_rd;
            dec.imm = imm_i;
            dec.alu_op       = ALU_ADDI;
            dec.mem_read     = 1'b1;
            dec.mem_to_reg   = 1'b1;
            dec.reg_write_en = 1'b1;
            dec.alu_src_imm  = 1'b1;
            dec.mem_size     = funct3[1:0];
            dec.mem_unsigned = funct3[2];
            bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
         end
         OPC_STORE: begin
            dec.rs1 = f_rs1;
            dec.rs2 = f_rs2;
            dec.imm = imm_s;
            dec.alu_op      = ALU_ADDI;
            dec.mem_write   = 1'b1;
            dec.alu_src_imm = 1'b1;
            dec.mem_size    = funct3[1:0];
            bad = (funct3 > 3'd2);
         end
         OPC_BRANCH: begin
            dec.rs1 = f_rs1;
            dec.rs2 = f_rs2;
            dec.imm = imm_b;
            dec.alu_op = ALU_SUB;
            case (funct3)
               3'd0:    dec.branch_type = 3'd1;
               3'd1:    dec.branch_type = 3'd2;
               3'd4:    dec.branch_type = 3'd3;
               3'd5:    dec.branch_type = 3'd4;
               3'd6:    dec.branch_type = 3'd5;
               3'd7:    dec.branch_type = 3'd6;
               default: bad = 1'b1;
            endcase
         end
         OPC_JAL: begin
            dec.rd  = f_rd;
            dec.imm = imm_j;
            dec.alu_op       = ALU_ADD;
            dec.jump         = 1'b1;
            dec.reg_write_en = 1'b1;
         end
         OPC_JALR: begin
            dec.rs1 = f_rs1;
            dec.rd  = f_rd;
            dec.imm = imm_i;
            dec.alu_op       = ALU_ADDI;
            dec.jump         = 1'b1;
            dec.jump_reg     = 1'b1;
            dec.reg_write_en = 1'b1;
            bad = (funct3 != 3'd0);
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.rd  = f_rd;
            dec.imm = imm_u;
            dec.alu_op       = (opcode == OPC_LUI) ? ALU_IMM : ALU_AUIPC;
            dec.reg_write_en = 1'b1;
            dec.alu_src_imm  = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         dec         = '0;
         dec.pc      = in_pc;
         dec.illegal = 1'b1;
      end
   end

   assign in_ready  = (count_q < DEPTH_CNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   // Pointer/count/counter next state; flush wins over any same-cycle push or pop.
   always_comb begin
      head_d          = head_q;
      tail_d          = tail_q;
      count_d         = count_q;
      illegal_count_d = illegal_count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
         if (pop)  head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
      if (push && dec.illegal && (illegal_count_q != 16'hFFFF))
         illegal_count_d = illegal_count_q + 1'b1;
   end

   // Buffer control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         illegal_count_q <= '0;
      end else begin
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         illegal_count_q <= illegal_count_d;
      end
   end

   // Buffer storage; cleared on reset so every out_* reads zero afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      end else if (push) begin
         buf_q[tail_q] <= dec;
      end
   end

   assign head             = buf_q[head_q];
   assign out_pc           = head.pc;
   assign out_alu_op       = head.alu_op;
   assign out_imm          = head.imm;
   assign out_rs1          = head.rs1;
   assign out_rs2          = head.rs2;
   assign out_rd           = head.rd;
   assign out_reg_write_en = head.reg_write_en;
   assign out_alu_src_imm  = head.alu_src_imm;
   assign out_mem_read     = head.mem_read;
   assign out_mem_write    = head.mem_write;
   assign out_mem_to_reg   = head.mem_to_reg;
   assign out_mem_unsigned = head.mem_unsigned;
   assign out_jump         = head.jump;
   assign out_jump_reg     = head.jump_reg;
   assign out_mem_size     = head.mem_size;
   assign out_branch_type  = head.branch_type;
   assign out_illegal      = head.illegal;
   assign illegal_count    = illegal_count_q;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Directed bench for decode_control_pipe (BUF_DEPTH = 2).
module tb_decode_control_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  out_alu_op;
   logic [31:0] out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_reg_write_en, out_alu_src_imm, out_mem_read, out_mem_write;
   logic        out_mem_to_reg, out_mem_unsigned, out_jump, out_jump_reg;
   logic [1:0]  out_mem_size;
   logic [2:0]  out_branch_type;
   logic        out_illegal;
   logic [15:0] illegal_count;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   decode_control_pipe #(.ADDR_W(32), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_alu_op(out_alu_op), .out_imm(out_imm),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_reg_write_en(out_reg_write_en), .out_alu_src_imm(out_alu_src_imm),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_to_reg(out_mem_to_reg), .out_mem_unsigned(out_mem_unsigned),
      .out_jump(out_jump), .out_jump_reg(out_jump_reg),
      .out_mem_size(out_mem_size), .out_branch_type(out_branch_type),
      .out_illegal(out_illegal), .illegal_count(illegal_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      in_valid = v;
      in_instr = instr;
      in_pc    = pc;
   endtask

   initial begin
      int stalls;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      repeat (3) step();
      rst = 1'b0;
      step();

      // reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_imm", out_imm, 0);
      check("rst_illegal_count", illegal_count, 0);

      // add x3,x1,x2
      drive(1'b1, 32'h002081B3, 32'h100);
      step();
      check("add_valid", out_valid, 1);
      check("add_pc", out_pc, 32'h100);
      check("add_alu", out_alu_op, 0);
      check("add_rd", out_rd, 3);
      check("add_rs1", out_rs1, 1);
      check("add_rs2", out_rs2, 2);
      check("add_rwe", out_reg_write_en, 1);
      check("add_imm", out_imm, 0);
      // sub x5,x6,x7 pushed while add pops
      out_ready = 1'b1;
      drive(1'b1, 32'h407302B3, 32'h104);
      step();
      check("sub_alu", out_alu_op, 2);
      check("sub_rd", out_rd, 5);
      check("sub_rs1", out_rs1, 6);
      check("sub_rs2", out_rs2, 7);
      // lb x1,-4(x2)
      drive(1'b1, 32'hFFC10083, 32'h108);
      step();
      check("lb_alu", out_alu_op, 1);
      check("lb_imm", out_imm, 32'hFFFFFFFC);
      check("lb_mem_read", out_mem_read, 1);
      check("lb_mem_size", out_mem_size, 0);
      check("lb_unsigned", out_mem_unsigned, 0);
      check("lb_mem_to_reg", out_mem_to_reg, 1);
      check("lb_rs2", out_rs2, 0);
      check("lb_rs1", out_rs1, 2);
      check("lb_alu_src", out_alu_src_imm, 1);
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("drain_valid", out_valid, 0);

      // back-pressure: three pushes into a 2-deep buffer
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h200);
      step();
      check("bp_ready1", in_ready, 1);
      drive(1'b1, 32'h00200113, 32'h204);
      step();
      check("bp_ready2", in_ready, 0);
      drive(1'b1, 32'h00300193, 32'h208);
      step();
      check("bp_hold_pc", out_pc, 32'h200);
      check("bp_hold_ready", in_ready, 0);
      out_ready = 1'b1;
      step();
      check("bp_second_pc", out_pc, 32'h204);
      check("bp_ready_after_pop", in_ready, 1);
      step();
      check("bp_third_pc", out_pc, 32'h208);
      check("bp_third_imm", out_imm, 3);
      check("bp_third_rd", out_rd, 3);
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("bp_drained", out_valid, 0);

      // streaming legal formats (head is the entry pushed this edge)
      drive(1'b1, 32'h00512423, 32'h300);   // sw x5,8(x2)
      step();
      check("sw_mem_write", out_mem_write, 1);
      check("sw_imm", out_imm, 8);
      check("sw_rd", out_rd, 0);
      check("sw_rs2", out_rs2, 5);
      check("sw_size", out_mem_size, 2);
      check("sw_rwe", out_reg_write_en, 0);
      drive(1'b1, 32'hFE209EE3, 32'h304);   // bne x1,x2,-4
      step();
      check("bne_type", out_branch_type, 2);
      check("bne_alu", out_alu_op, 2);
      check("bne_imm", out_imm, 32'hFFFFFFFC);
      check("bne_rd", out_rd, 0);
      drive(1'b1, 32'h123453B7, 32'h308);   // lui x7,0x12345
      step();
      check("lui_alu", out_alu_op, 16);
      check("lui_imm", out_imm, 32'h12345000);
      check("lui_rs1", out_rs1, 0);
      check("lui_rd", out_rd, 7);
      drive(1'b1, 32'h008000EF, 32'h30C);   // jal x1,8
      step();
      check("jal_jump", out_jump, 1);
      check("jal_jump_reg", out_jump_reg, 0);
      check("jal_imm", out_imm, 8);
      check("jal_rs2", out_rs2, 0);
      drive(1'b1, 32'h40315093, 32'h310);   // srai x1,x2,3
      step();
      check("srai_alu", out_alu_op, 9);
      check("srai_illegal", out_illegal, 0);

      // illegal encodings
      drive(1'b1, 32'h00000000, 32'h400);
      step();
      check("ill0_flag", out_illegal, 1);
      check("ill0_pc", out_pc, 32'h400);
      check("ill0_rwe", out_reg_write_en, 0);
      check("ill0_cnt", illegal_count, 1);
      drive(1'b1, 32'h0000700F, 32'h404);
      step();
      check("ill1_flag", out_illegal, 1);
      check("ill1_pc", out_pc, 32'h404);
      check("ill1_cnt", illegal_count, 2);
      drive(1'b1, 32'h000010E7, 32'h408);   // jalr funct3=1
      step();
      check("jalr_bad_flag", out_illegal, 1);
      check("jalr_bad_jump", out_jump, 0);
      drive(1'b1, 32'h02001093, 32'h40C);   // slli with funct7=0000001
      step();
      check("slli_bad_flag", out_illegal, 1);
      check("slli_bad_alu", out_alu_op, 0);
      check("slli_bad_imm", out_imm, 0);
      check("ill_cnt4", illegal_count, 4);

      // saturation with sustained throughput
      stalls = 0;
      drive(1'b1, 32'h00000000, 32'h500);
      for (int i = 0; i < 65535; i++) begin
         if (!in_ready) stalls++;
         step();
      end
      check("sustained_stalls", stalls, 0);
      check("sat_cnt", illegal_count, 16'hFFFF);
      step();
      check("sat_hold", illegal_count, 16'hFFFF);
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("sat_drained", out_valid, 0);

      // flush with full buffer and same-cycle input
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h600);
      step();
      drive(1'b1, 32'h00200113, 32'h604);
      step();
      check("fl_full", in_ready, 0);
      drive(1'b1, 32'h00300193, 32'h608);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check("fl_valid", out_valid, 0);
      check("fl_ready", in_ready, 1);
      check("fl_keeps_cnt", illegal_count, 16'hFFFF);
      drive(1'b1, 32'h00400213, 32'h60C);
      step();
      check("fl_new_pc", out_pc, 32'h60C);
      // flush drops a same-cycle push and pop while not full
      drive(1'b1, 32'h00500293, 32'h610);
      out_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check("fl2_valid", out_valid, 0);
      step();
      check("fl2_input_absent", out_valid, 0);

      // asynchronous reset mid-cycle with two entries held
      out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h700);
      step();
      drive(1'b1, 32'h00000000, 32'h704);
      step();
      drive(1'b0, 32'h0, 32'h0);
      check("ar_pre_ready", in_ready, 0);
      #3 rst = 1'b1;
      #1;
      check("ar_valid", out_valid, 0);
      check("ar_ready", in_ready, 1);
      check("ar_pc", out_pc, 0);
      check("ar_rd", out_rd, 0);
      check("ar_rwe", out_reg_write_en, 0);
      check("ar_cnt", illegal_count, 0);
      step();
      rst = 1'b0;
      step();
      check("ar_after_valid", out_valid, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/decode_control_pipe.md
# decode_control_pipe

Registered, parametrised successor to the combinational RV32 control logic unit. It decodes the full 32-bit RV32I instruction and emits the ALU op, immediate, register indices and memory/branch/jump controls. Results sit in a small in-order output buffer with valid/ready handshakes on both sides, and the block supports pipeline flush and illegal-instruction accounting. It sits between fetch and the register-read/execute stage.

## Interface
- `ADDR_W`, default 32: PC width carried alongside each instruction.
- `BUF_DEPTH`, default 2: output buffer entries; legal values are 1, 2 and 4.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: fetch offers an instruction.
- `in_ready` output 1: block can accept an instruction.
- `in_instr` input 32: instruction word.
- `in_pc` input `ADDR_W`: PC of `in_instr`.
- `flush` input 1: discard all buffered entries and any same-cycle input.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: downstream consumes the head.
- `out_pc` output `ADDR_W`: PC of the head entry.
- `out_alu_op` output 5: ALU op code, encoded as listed under Operation.
- `out_imm` output 32: sign-extended or U-type immediate; 0 for R-type.
- `out_rs1`, `out_rs2`, `out_rd` output 5 each: register indices; a field is forced to 0 when the format does not use it.
- `out_reg_write_en`, `out_alu_src_imm`, `out_mem_read`, `out_mem_write`, `out_mem_to_reg`, `out_mem_unsigned`, `out_jump`, `out_jump_reg` output 1 each: control flags.
- `out_mem_size` output 2: 0 = byte, 1 = half, 2 = word.
- `out_branch_type` output 3: 0 = none, 1 = BEQ, 2 = BNE, 3 = BLT, 4 = BGE, 5 = BLTU, 6 = BGEU.
- `out_illegal` output 1: head entry was an illegal encoding.
- `illegal_count` output 16: count of accepted illegal instructions; saturating.

## Operation
- ALU op encoding: ADD 0, ADDI 1, SUB 2, SLL 4, SLLI 5, SRL 6, SRLI 7, SRA 8, SRAI 9, AND 10, ANDI 11, OR 12, ORI 13, XOR 14, XORI 15, IMM 16 (LUI pass-through), SLT 17, SLTU 18, SLTI 19, SLTIU 20, AUIPC 21.
- Loads, stores and JALR use ADDI. Branches use SUB. JAL uses ADD.
- R-type: `reg_write_en` = 1; all other controls 0.
- OP-IMM: `alu_src_imm` = 1, `reg_write_en` = 1. Shift-immediates require `instr[31:25]` = 0000000, or 0100000 for SRAI; otherwise the instruction is illegal.
- Loads: `mem_read` = `mem_to_reg` = `reg_write_en` = `alu_src_imm` = 1. `mem_size` = funct3[1:0]; `mem_unsigned` = funct3[2]. funct3 values 3, 6 and 7 are illegal.
- Stores: `mem_write` = 1 and `alu_src_imm` = 1. funct3 greater than 2 is illegal.
- Branches: `branch_type` is taken from funct3. funct3 values 2 and 3 are illegal.
- JAL: `jump` = 1, `reg_write_en` = 1.
- JALR: `jump` = `jump_reg` = 1, `reg_write_en` = 1. funct3 ≠ 0 is illegal.
- LUI and AUIPC: `reg_write_en` = 1, `alu_src_imm` = 1.
- Illegal instructions are: `instr[1:0]` ≠ 11, an unknown opcode, or any invalid funct3/funct7 listed above. An illegal entry has every enable 0, `alu_op` 0, `imm` 0 and `illegal` = 1. The entry is still buffered and delivered with its PC.
- The buffer is a circular FIFO with head/tail pointers and a count of 0..`BUF_DEPTH`.
  - Push: `in_valid && in_ready && !flush`.
  - Pop: `out_valid && out_ready`.
  - Push and pop in the same cycle leave the count unchanged; order is strictly preserved.
- `illegal_count` increments on a push of an illegal entry and holds at 0xFFFF. A flush does not clear it.

## Timing
- Reset: count 0, pointers 0, `illegal_count` 0, all buffer data 0. Therefore all `out_*` outputs read 0, `out_valid` = 0 and `in_ready` = 1.
- A reset asserted mid-operation takes effect immediately and discards all entries.
- Latency: an instruction accepted at edge N is visible at the head after edge N, provided the buffer was empty.
- `in_ready` = (count < `BUF_DEPTH`). There is no combinational path from `out_ready` to `in_ready`.
- `out_valid` = (count ≠ 0), and `out_*` come straight from the head entry register.
- When the buffer is full, a pop at edge N raises `in_ready` after edge N.
- With `BUF_DEPTH` ≥ 2, sustained `out_ready` gives 1 instruction per cycle. With `BUF_DEPTH` = 1, the maximum is 1 instruction per 2 cycles.
- Flush at edge N sets the count to 0 and drops both the same-cycle push and the same-cycle pop. `out_valid` = 0 after edge N.
- An entry is held stable while `out_valid && !out_ready`.

## Test plan
- Reset, then push `0x002081B3` (add x3,x1,x2) → next cycle `out_valid` = 1, `alu_op` 0, `rd` 3, `rs1` 1, `rs2` 2, `reg_write_en` 1, `imm` 0. Push `0x407302B3` → `alu_op` 2, `rd` 5, `rs1` 6, `rs2` 7.
- Push `0xFFC10083` (lb x1,-4(x2)) → `alu_op` 1, `imm` 0xFFFFFFFC, `mem_read` 1, `mem_size` 0, `mem_unsigned` 0, `mem_to_reg` 1, `rs2` 0.
- `BUF_DEPTH` = 2, `out_ready` = 0, push three instructions back-to-back → `in_ready` falls after the 2nd push and the 3rd is held. Raise `out_ready` → the three emerge in order on consecutive cycles.
- Push `0x00000000`, then push `0x0000700F` with funct3 invalid for its opcode → both are delivered with `illegal` = 1 and `illegal_count` = 2. Force the counter to 0xFFFF via 65535 pushes → it stays at 0xFFFF.
- Fill the buffer, then assert `flush` with `in_valid` = 1 in the same cycle → next cycle `out_valid` = 0, `in_ready` = 1, and the flushed-cycle input is absent.
- Assert `rst` asynchronously between edges while the buffer holds 2 entries → all outputs read 0 immediately, `out_valid` = 0, and `illegal_count` = 0.
